// File: rtl/manchester_frame_decoder_pkg.sv
// Shared types and helpers for the Manchester frame decoder.
package manchester_pkg;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        TIMING  = 2'd1,
        LOOKING = 2'd2,
        FOUND   = 2'd3
    } state_t;

    // A falling mid-bit edge means 1 at normal polarity; polarity inverts it.
    function automatic logic decode_bit(input logic neg_edge, input logic polarity);
        return neg_edge ^ polarity;
    endfunction

endpackage

// File: rtl/manchester_frame_decoder_deserializer.sv
// Collects decoded bits into words and presents each completed word.
module manchester_deserializer
    import manchester_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    parameter int CW         = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bit_in,
    input  logic                  bit_strobe,
    input  logic                  clear,
    output logic [CW-1:0]         bit_count,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  word_valid
);

    logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
    logic [CW-1:0]         bit_count_q, bit_count_d;
    logic [DATA_WIDTH-1:0] word_data_q, word_data_d;
    logic                  word_valid_q, word_valid_d;

    // Shift in new bits, and hand the full word out on the tick its last bit lands.
    always_comb begin
        shift_d      = shift_q;
        bit_count_d  = bit_count_q;
        word_data_d  = word_data_q;
        word_valid_d = 1'b0;
        if (MSB_FIRST != 0) begin
            shifted = {shift_q[DATA_WIDTH-2:0], bit_in};
        end else begin
            shifted = {bit_in, shift_q[DATA_WIDTH-1:1]};
        end
        if (clear) begin
            shift_d     = '0;
            bit_count_d = '0;
        end else if (bit_strobe) begin
            if (bit_count_q == CW'(DATA_WIDTH - 1)) begin
                word_data_d  = shifted;
                word_valid_d = 1'b1;
                bit_count_d  = '0;
                shift_d      = '0;
            end else begin
                shift_d     = shifted;
                bit_count_d = bit_count_q + CW'(1);
            end
        end
    end

    // Deserialiser state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q      <= '0;
            bit_count_q  <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_count_q  <= bit_count_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign bit_count  = bit_count_q;
    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;

endmodule

// File: rtl/manchester_frame_decoder.sv
// Manchester bit recovery from pre-detected line edges, with framing and word assembly.
module manchester_frame_decoder
    import manchester_pkg::*;
#(
    parameter int HALF_PERIOD = 9,
    parameter int DATA_WIDTH  = 8,
    parameter int POLARITY    = 0,
    parameter int MSB_FIRST   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pos_edge,
    input  logic                  neg_edge,
    output logic                  manchester_clock,
    output logic                  manchester_data,
    output logic                  transmission_begin,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  word_valid,
    output logic                  frame_end,
    output logic                  frame_error
);

    localparam int   QUARTER = HALF_PERIOD / 2;
    localparam int   TW      = $clog2(HALF_PERIOD + 1);
    localparam int   CW      = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] QUARTER_T = TW'(QUARTER);
    localparam logic [TW-1:0] HALF_T    = TW'(HALF_PERIOD);
    localparam logic POL_BIT = (POLARITY != 0);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          mclk_q, mclk_d;
    logic          mdata_q, mdata_d;
    logic          begin_q, begin_d;
    logic          fend_q, fend_d;
    logic          ferr_q, ferr_d;
    logic          bit_strobe, des_clear, bit_val;
    logic [CW-1:0] bit_count;

    // Edge-timing FSM: next state, timer and registered output values per enabled tick.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        mclk_d     = mclk_q;
        mdata_d    = mdata_q;
        begin_d    = 1'b0;
        fend_d     = 1'b0;
        ferr_d     = 1'b0;
        bit_strobe = 1'b0;
        des_clear  = 1'b0;
        bit_val    = decode_bit(neg_edge, POL_BIT);
        if (enable) begin
            timer_d = '0;
            mclk_d  = 1'b0;
            case (state_q)
                ARMED: begin
                    if (pos_edge) begin
                        state_d   = TIMING;
                        begin_d   = 1'b1;
                        des_clear = 1'b1;
                    end
                end
                TIMING: begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q > QUARTER_T) begin
                        state_d = LOOKING;
                        timer_d = '0;
                    end
                end
                LOOKING: begin
                    timer_d = timer_q + TW'(1);
                    if (pos_edge && neg_edge) begin
                        ferr_d    = 1'b1;
                        state_d   = ARMED;
                        des_clear = 1'b1;
                        timer_d   = '0;
                    end else if (pos_edge || neg_edge) begin
                        mdata_d    = bit_val;
                        mclk_d     = 1'b1;
                        bit_strobe = 1'b1;
                        timer_d    = '0;
                        state_d    = FOUND;
                    end else if (timer_q >= HALF_T) begin
                        state_d   = ARMED;
                        fend_d    = 1'b1;
                        ferr_d    = (bit_count != '0);
                        des_clear = 1'b1;
                        timer_d   = '0;
                    end
                end
                FOUND: begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q >= QUARTER_T) begin
                        state_d = TIMING;
                        timer_d = '0;
                    end
                end
                default: state_d = ARMED;
            endcase
        end
    end

    // FSM state, timer and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ARMED;
            timer_q <= '0;
            mclk_q  <= 1'b0;
            mdata_q <= 1'b0;
            begin_q <= 1'b0;
            fend_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mclk_q  <= mclk_d;
            mdata_q <= mdata_d;
            begin_q <= begin_d;
            fend_q  <= fend_d;
            ferr_q  <= ferr_d;
        end
    end

    manchester_deserializer #(
        .DATA_WIDTH(DATA_WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CW        (CW)
    ) u_deser (
        .clock     (clock),
        .reset     (reset),
        .bit_in    (bit_val),
        .bit_strobe(bit_strobe),
        .clear     (des_clear),
        .bit_count (bit_count),
        .word_data (word_data),
        .word_valid(word_valid)
    );

    assign manchester_clock   = mclk_q;
    assign manchester_data    = mdata_q;
    assign transmission_begin = begin_q;
    assign frame_end          = fend_q;
    assign frame_error        = ferr_q;

endmodule

// File: tb/tb_manchester_frame_decoder.sv
// Scoreboard bench for the Manchester frame decoder (normal and inverted polarity).
module tb_manchester_frame_decoder;

    localparam logic [2:0] K_BEGIN = 3'd0;
    localparam logic [2:0] K_BIT   = 3'd1;
    localparam logic [2:0] K_WORD  = 3'd2;
    localparam logic [2:0] K_FEND  = 3'd3;
    localparam logic [2:0] K_FERR  = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] val;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable0 = 1'b0, enable1 = 1'b0;
    logic pos_edge = 1'b0, neg_edge = 1'b0;
    int   sel = 0;
    int   total = 0, bad = 0;

    logic       mclk0, mdata0, tb0, wv0, fe0, fer0;
    logic [7:0] wd0;
    logic       mclk1, mdata1, tb1, wv1, fe1, fer1;
    logic [7:0] wd1;

    ev_t q0[$];
    ev_t q1[$];

    manchester_frame_decoder #(.HALF_PERIOD(9), .DATA_WIDTH(8), .POLARITY(0), .MSB_FIRST(1)) dut0 (
        .clock(clock), .reset(reset), .enable(enable0), .pos_edge(pos_edge), .neg_edge(neg_edge),
        .manchester_clock(mclk0), .manchester_data(mdata0), .transmission_begin(tb0),
        .word_data(wd0), .word_valid(wv0), .frame_end(fe0), .frame_error(fer0)
    );

    manchester_frame_decoder #(.HALF_PERIOD(9), .DATA_WIDTH(8), .POLARITY(1), .MSB_FIRST(1)) dut1 (
        .clock(clock), .reset(reset), .enable(enable1), .pos_edge(pos_edge), .neg_edge(neg_edge),
        .manchester_clock(mclk1), .manchester_data(mdata1), .transmission_begin(tb1),
        .word_data(wd1), .word_valid(wv1), .frame_end(fe1), .frame_error(fer1)
    );

    // Free-running system clock.
    always #5 clock = ~clock;

    function automatic ev_t mk_ev(input logic [2:0] kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        return e;
    endfunction

    task automatic push_exp(input logic [2:0] kind, input logic [7:0] val);
        if (sel == 0) q0.push_back(mk_ev(kind, val));
        else          q1.push_back(mk_ev(kind, val));
    endtask

    task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pops the next expected event for one instance and compares it with what it produced.
    task automatic checkOutput(input int which, input ev_t obs);
        ev_t e;
        total++;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            bad++;
            $display("[TB] FAIL dut%0d unexpected event: got kind=%0d val=%0h expected none", which, obs.kind, obs.val);
        end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            if (e !== obs) begin
                bad++;
                $display("[TB] FAIL dut%0d event: got kind=%0d val=%0h expected kind=%0d val=%0h @%0t",
                         which, obs.kind, obs.val, e.kind, e.val, $time);
            end
        end
    endtask

    // Monitor for the normal-polarity instance, sampling on the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (tb0)   checkOutput(0, mk_ev(K_BEGIN, 8'h00));
            if (mclk0) checkOutput(0, mk_ev(K_BIT, {7'b0, mdata0}));
            if (wv0)   checkOutput(0, mk_ev(K_WORD, wd0));
            if (fe0)   checkOutput(0, mk_ev(K_FEND, 8'h00));
            if (fer0)  checkOutput(0, mk_ev(K_FERR, 8'h00));
        end
    end

    // Monitor for the inverted-polarity instance.
    always @(negedge clock) begin
        if (!reset) begin
            if (tb1)   checkOutput(1, mk_ev(K_BEGIN, 8'h00));
            if (mclk1) checkOutput(1, mk_ev(K_BIT, {7'b0, mdata1}));
            if (wv1)   checkOutput(1, mk_ev(K_WORD, wd1));
            if (fe1)   checkOutput(1, mk_ev(K_FEND, 8'h00));
            if (fer1)  checkOutput(1, mk_ev(K_FERR, 8'h00));
        end
    end

    // One clock of stimulus; enable goes only to the selected instance.
    task automatic step(input logic p, input logic n, input logic en);
        pos_edge = p;
        neg_edge = n;
        enable0  = en && (sel == 0);
        enable1  = en && (sel == 1);
        @(posedge clock);
        #1;
        pos_edge = 1'b0;
        neg_edge = 1'b0;
        enable0  = 1'b0;
        enable1  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1);
    endtask

    // Start edge, then nbits mid-bit edges of w (MSB first, falling edge = 1 on the line),
    // optionally with 5 disabled clocks inside each TIMING window, optionally idling to timeout.
    task automatic applyStimulus(input logic [7:0] w, input int nbits, input bit gaps, input bit tail);
        logic b;
        push_exp(K_BEGIN, 8'h00);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < ((i == 0) ? 8 : 17); k++) begin
                if (gaps && k == ((i == 0) ? 3 : 7)) begin
                    for (int g = 0; g < 5; g++) step(1'b0, 1'b0, 1'b0);
                end
                step(1'b0, 1'b0, 1'b1);
            end
            b = w[7-i];
            step(!b, b, 1'b1);
            push_exp(K_BIT, {7'b0, b ^ (sel == 1)});
            if (i == 7) push_exp(K_WORD, w ^ {8{sel == 1}});
        end
        if (tail) begin
            push_exp(K_FEND, 8'h00);
            if (nbits % 8 != 0) push_exp(K_FERR, 8'h00);
            idle(25);
        end
    endtask

    initial begin
        // Reset takes effect before any clock edge.
        #3;
        checkValue("reset word_data0", wd0, 8'h00);
        checkValue("reset outputs0", {2'b0, mclk0, mdata0, tb0, wv0, fe0, fer0}, 8'h00);
        checkValue("reset outputs1", {2'b0, mclk1, mdata1, tb1, wv1, fe1, fer1}, 8'h00);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(3);

        // Full word 0xA5.
        applyStimulus(8'hA5, 8, 1'b0, 1'b1);

        // Three bits then silence: timeout exactly 10 ticks after LOOKING entry.
        applyStimulus(8'hA5, 3, 1'b0, 1'b0);
        push_exp(K_FEND, 8'h00);
        push_exp(K_FERR, 8'h00);
        idle(20);
        checkValue("t2 frame_end early", 8'(fe0), 8'h00);
        idle(1);
        checkValue("t2 frame_end", 8'(fe0), 8'h01);
        checkValue("t2 frame_error", 8'(fer0), 8'h01);
        idle(4);

        // Exactly 8 bits then timeout: clean frame end.
        applyStimulus(8'h3C, 8, 1'b0, 1'b1);

        // Illegal simultaneous edges after one bit.
        applyStimulus(8'h80, 1, 1'b0, 1'b0);
        idle(17);
        step(1'b1, 1'b1, 1'b1);
        push_exp(K_FERR, 8'h00);
        idle(3);
        checkValue("t4 word_data held", wd0, 8'h3C);

        // Enable gaps inside every bit.
        applyStimulus(8'h5A, 8, 1'b1, 1'b1);
        checkValue("t5 word_data", wd0, 8'h5A);

        // Async reset mid-word, then a clean resend.
        applyStimulus(8'hA5, 4, 1'b0, 1'b0);
        idle(3);
        #2;
        reset = 1'b1;
        #1;
        checkValue("t6 reset word_data", wd0, 8'h00);
        checkValue("t6 reset outputs", {2'b0, mclk0, mdata0, tb0, wv0, fe0, fer0}, 8'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(3);
        applyStimulus(8'hA5, 8, 1'b0, 1'b1);

        // Same line pattern into the inverted-polarity instance.
        sel = 1;
        applyStimulus(8'hA5, 8, 1'b0, 1'b1);
        checkValue("t6 inverted word_data", wd1, 8'h5A);
        idle(5);

        checkValue("leftover expected dut0", 8'(q0.size()), 8'h00);
        checkValue("leftover expected dut1", 8'(q1.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
